bl_zone_spi_tx: RTL and testbench

- Downstream consumer of the 360-zone backlight stage.
- Captures each zone value into a ping-pong zone RAM as it is produced (zone_done strobe).
- On every frame boundary (rising edge of r_Vsync_0), swaps banks and serialises the completed frame of 360 12-bit PWM words to the MiniLED driver chain over a SPI-like link, followed by a latch pulse.

---
 rtl/bl_pkg.sv | 29 ++
 rtl/bl_zone_ram.sv | 24 ++
 rtl/bl_zone_spi_tx.sv | 259 +++++++++++++++++++++++++
 tb/tb_bl_zone_spi_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bl_pkg.sv
// Shared types and helpers for the backlight zone SPI transmitter.
// Optional build macro: BL_GAMMA_EN selects the squared (gamma) word mapping
// instead of linear bit replication.
package bl_pkg;

    localparam int ZONES_DEFAULT = 360;
    localparam int WORD_W        = 12;
    localparam int ZIDX_W        = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        NEXT,
        LATCH
    } bl_state_e;

    // Map an 8-bit zone level onto a 12-bit PWM word; a disabled backlight sends 0.
    function automatic logic [WORD_W-1:0] bl_word(input logic [7:0] v, input logic en);
        logic [WORD_W-1:0] w;
`ifdef BL_GAMMA_EN
        w = WORD_W'((16'(v) * 16'(v)) >> 4);
`else
        w = {v, v[7:4]};
`endif
        return en ? w : '0;
    endfunction

endpackage

// File: rtl/bl_zone_ram.sv
// Ping-pong zone store: one write port, one registered read port.
// Address is {bank, zone index}, so each bank occupies a power-of-two half.
module bl_zone_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    // Write when asked, read every cycle with one cycle of latency.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bl_zone_spi_tx.sv
// Backlight zone SPI transmitter: captures zone levels into a ping-pong RAM and,
// on each rising r_Vsync_0, streams the completed frame as 12-bit words MSB first,
// then pulses spi_latch. Build macro BL_GAMMA_EN adds one LOAD cycle for the
// registered square used by the gamma mapping.
module bl_zone_spi_tx
    import bl_pkg::*;
#(
    parameter int ZONES     = ZONES_DEFAULT,
    parameter int CLK_DIV   = 4,
    parameter int LATCH_LEN = 8
) (
    input  logic              i_pix_clk,
    input  logic              rst,
    input  logic              zone_done,
    input  logic [ZIDX_W-1:0] zone_idx,
    input  logic [7:0]        zone_val,
    input  logic              r_Vsync_0,
    input  logic              bl_enable,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              spi_latch,
    output logic              tx_busy,
    output logic              frame_drop,
    output logic              zone_err
);

    localparam logic [ZIDX_W-1:0] LAST_IDX = ZIDX_W'(ZONES - 1);
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int                LAT_W    = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_LEN - 1);
`ifdef BL_GAMMA_EN
    localparam logic [1:0]        LOAD_LAST = 2'd2;
`else
    localparam logic [1:0]        LOAD_LAST = 2'd1;
`endif

    bl_state_e         state_q, state_d;
    logic              vs_q, vs_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              dirty_q, dirty_d;
    logic [ZIDX_W-1:0] zidx_q, zidx_d;
    logic [1:0]        load_cnt_q, load_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              phase_q, phase_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              latch_q, latch_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
`ifdef BL_GAMMA_EN
    logic [15:0]       prod_q, prod_d;
`endif

    logic              boundary;
    logic              ram_we;
    logic [7:0]        rd_data;
    logic [WORD_W-1:0] word;

    assign ram_we = zone_done && (zone_idx <= LAST_IDX);

    bl_zone_ram #(.AW(ZIDX_W + 1)) u_ram (
        .clk   (i_pix_clk),
        .we    (ram_we),
        .waddr ({wr_bank_q, zone_idx}),
        .wdata (zone_val),
        .raddr ({rd_bank_q, zidx_q}),
        .rdata (rd_data)
    );

    // Next-state logic: write bookkeeping, frame boundary handling and the TX sequencer.
    always_comb begin
        state_d    = state_q;
        vs_d       = r_Vsync_0;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        dirty_d    = dirty_q;
        zidx_d     = zidx_q;
        load_cnt_d = load_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        sh_d       = sh_q;
        lat_cnt_d  = lat_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        latch_d    = latch_q;
        busy_d     = busy_q;
        drop_d     = 1'b0;
        err_d      = err_q;
`ifdef BL_GAMMA_EN
        prod_d     = prod_q;
`endif
        word       = '0;
        boundary   = r_Vsync_0 && !vs_q;

        if (zone_done && (zone_idx > LAST_IDX)) begin
            err_d = 1'b1;
        end
        if (ram_we) begin
            dirty_d = 1'b1;
        end
        // A boundary while transmitting is reported and otherwise ignored.
        if (boundary && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // The swap wins over a same-cycle write, which lands in the bank being sent.
                if (boundary && dirty_q) begin
                    rd_bank_d  = wr_bank_q;
                    wr_bank_d  = !wr_bank_q;
                    dirty_d    = 1'b0;
                    zidx_d     = '0;
                    load_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
`ifdef BL_GAMMA_EN
                    word = bl_enable ? WORD_W'(prod_q >> 4) : '0;
`else
                    word = bl_word(rd_data, bl_enable);
`endif
                    sh_d      = word;
                    mosi_d    = word[WORD_W-1];
                    sclk_d    = 1'b0;
                    bit_cnt_d = 4'(WORD_W - 1);
                    div_cnt_d = '0;
                    phase_d   = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
`ifdef BL_GAMMA_EN
                    if (load_cnt_q == 2'd1) begin
                        prod_d = 16'(rd_data) * 16'(rd_data);
                    end
`endif
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_cnt_q == 4'd0) begin
                            state_d = NEXT;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                            sh_d      = sh_q << 1;
                            mosi_d    = sh_d[WORD_W-1];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (zidx_q < LAST_IDX) begin
                    zidx_d     = zidx_q + 1'b1;
                    load_cnt_d = '0;
                    state_d    = LOAD;
                end else begin
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    latch_d   = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops the link to idle immediately.
    always_ff @(posedge i_pix_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            dirty_q    <= 1'b0;
            zidx_q     <= '0;
            load_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            phase_q    <= 1'b0;
            sh_q       <= '0;
            lat_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef BL_GAMMA_EN
            prod_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            dirty_q    <= dirty_d;
            zidx_q     <= zidx_d;
            load_cnt_q <= load_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
            sh_q       <= sh_d;
            lat_cnt_q  <= lat_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
`ifdef BL_GAMMA_EN
            prod_q     <= prod_d;
`endif
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_latch  = latch_q;
    assign tx_busy    = busy_q;
    assign frame_drop = drop_q;
    assign zone_err   = err_q;

endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// Testbench for bl_zone_spi_tx: random zone frames, a two-bank reference model,
// and an SPI decoder that checks each received word against a scoreboard queue.
// Honours BL_GAMMA_EN for the expected word mapping.
module tb_bl_zone_spi_tx;

    localparam int ZONES = 360;
    localparam int NBITS = 12 * ZONES;
    localparam int LATL  = 4;

    logic       i_pix_clk = 1'b0;
    logic       rst       = 1'b1;
    logic       zone_done = 1'b0;
    logic [8:0] zone_idx  = '0;
    logic [7:0] zone_val  = '0;
    logic       r_Vsync_0 = 1'b0;
    logic       bl_enable = 1'b1;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_latch, tx_busy, frame_drop, zone_err;

    always #5 i_pix_clk = ~i_pix_clk;

    bl_zone_spi_tx #(.ZONES(ZONES), .CLK_DIV(1), .LATCH_LEN(LATL)) dut (
        .i_pix_clk (i_pix_clk),
        .rst       (rst),
        .zone_done (zone_done),
        .zone_idx  (zone_idx),
        .zone_val  (zone_val),
        .r_Vsync_0 (r_Vsync_0),
        .bl_enable (bl_enable),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_latch (spi_latch),
        .tx_busy   (tx_busy),
        .frame_drop(frame_drop),
        .zone_err  (zone_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int model_ram [2][ZONES];
    int m_wr = 0;
    int got_words [ZONES];
    int word_idx = 0;
    int latch_pulses = 0;

    // Reference mapping straight from the word rules.
    function automatic int ref_word(int v, bit en);
        if (!en) return 0;
`ifdef BL_GAMMA_EN
        return (v * v) / 16;
`else
        return v * 16 + v / 16;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: decode the SPI stream and check framing and latch timing.
    int         bits = 0, rises = 0, lat_run = 0, e;
    logic [11:0] sr = '0;
    logic       sclk_prev = 1'b0, cs_prev = 1'b1, lat_prev = 1'b0;
    always @(negedge i_pix_clk) begin
        if (rst) begin
            bits = 0; rises = 0; word_idx = 0; lat_run = 0;
            sclk_prev = 1'b0; cs_prev = 1'b1; lat_prev = 1'b0;
        end else begin
            if (cs_prev && !spi_cs_n) begin
                bits = 0; rises = 0; word_idx = 0;
            end
            if (!cs_prev && spi_cs_n) begin
                check("sclk_rises", rises, NBITS);
                check("latch_at_cs_rise", int'(spi_latch), 1);
            end
            if (!spi_cs_n && spi_sclk && !sclk_prev) begin
                sr = {sr[10:0], spi_mosi};
                bits++; rises++;
                if (bits == 12) begin
                    bits = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL word_unexpected: got 0x%0h, expected no word", sr);
                    end else begin
                        e = exp_q.pop_front();
                        if (word_idx < 3 || (word_idx % 60) == 0 || int'(sr) != e)
                            check($sformatf("word_z%0d", word_idx), int'(sr), e);
                        else begin
                            n_cmp++;
                        end
                    end
                    if (word_idx < ZONES) got_words[word_idx] = int'(sr);
                    word_idx++;
                end
            end
            if (spi_latch) lat_run++;
            if (lat_prev && !spi_latch) begin
                check("latch_len", lat_run, LATL);
                check("busy_after_latch", int'(tx_busy), 0);
                latch_pulses++;
                lat_run = 0;
            end
            sclk_prev = spi_sclk;
            cs_prev   = spi_cs_n;
            lat_prev  = spi_latch;
        end
    end

    task automatic tick();
        @(posedge i_pix_clk); #1;
    endtask

    task automatic wr(int idx, int val);
        zone_done = 1'b1;
        zone_idx  = idx[8:0];
        zone_val  = val[7:0];
        if (idx < ZONES) model_ram[m_wr][idx] = val & 255;
        tick();
        zone_done = 1'b0;
    endtask

    task automatic start_frame();
        for (int k = 0; k < ZONES; k++) exp_q.push_back(ref_word(model_ram[m_wr][k], bl_enable));
        m_wr ^= 1;
        r_Vsync_0 = 1'b1;
        @(negedge i_pix_clk); check("busy_before_edge", int'(tx_busy), 0);
        @(negedge i_pix_clk); check("busy_after_edge", int'(tx_busy), 1);
        @(posedge i_pix_clk); #1 r_Vsync_0 = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (tx_busy && n < 20000) begin
            @(negedge i_pix_clk); n++;
        end
        if (n >= 20000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: tx_busy still 1 after %0d cycles, expected 0", name, n);
        end
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_word_count"}, word_idx, ZONES);
        tick();
    endtask

    int lp;
    initial begin
        // Reset state
        @(negedge i_pix_clk);
        check("rst_sclk", int'(spi_sclk), 0);
        check("rst_mosi", int'(spi_mosi), 0);
        check("rst_cs_n", int'(spi_cs_n), 1);
        check("rst_latch", int'(spi_latch), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_drop", int'(frame_drop), 0);
        check("rst_err", int'(zone_err), 0);
        @(posedge i_pix_clk); #1 rst = 1'b0;
        tick();

        // Frame 1: ramp k[7:0]
        for (int k = 0; k < ZONES; k++) wr(k, k & 255);
        start_frame();
        // Second boundary while shifting must be dropped for exactly one cycle
        repeat (200) @(posedge i_pix_clk);
        #1 r_Vsync_0 = 1'b1;
        @(negedge i_pix_clk); check("drop_pre", int'(frame_drop), 0);
        @(negedge i_pix_clk); check("drop_pulse", int'(frame_drop), 1);
        @(negedge i_pix_clk); check("drop_end", int'(frame_drop), 0);
        check("busy_during_drop", int'(tx_busy), 1);
        @(posedge i_pix_clk); #1 r_Vsync_0 = 1'b0;
        // Fill the other bank while frame 1 is on the wire
        for (int k = 0; k < ZONES; k++) wr(k, $urandom_range(0, 255));
        wr(0, 8'h80); wr(1, 8'hFF); wr(2, 8'h10); wr(5, 8'hAA);
        wait_idle("f1");
`ifdef BL_GAMMA_EN
        check("f1_z1", got_words[1], 12'h000);
        check("f1_z255", got_words[255], 12'hFE0);
        check("f1_z300", got_words[300], 12'h079);
`else
        check("f1_z0", got_words[0], 12'h000);
        check("f1_z1", got_words[1], 12'h010);
        check("f1_z255", got_words[255], 12'hFFF);
        check("f1_z300", got_words[300], 12'h2C2);
`endif

        // Frame 2: bank written during frame 1
        start_frame();
        wait_idle("f2");
`ifdef BL_GAMMA_EN
        check("f2_z0", got_words[0], 12'h400);
        check("f2_z1", got_words[1], 12'hFE0);
        check("f2_z2", got_words[2], 12'h010);
        check("f2_z5", got_words[5], 12'h70E);
`else
        check("f2_z0", got_words[0], 12'h808);
        check("f2_z1", got_words[1], 12'hFFF);
        check("f2_z2", got_words[2], 12'h101);
        check("f2_z5", got_words[5], 12'hAAA);
`endif

        // Out-of-range index: sticky error, no write
        check("err_before", int'(zone_err), 0);
        wr(360, 8'h55);
        @(negedge i_pix_clk); check("err_set", int'(zone_err), 1);
        wr(511, 8'h55);
        for (int k = 0; k < 20; k++) wr($urandom_range(0, ZONES - 1), $urandom_range(0, 255));
        start_frame();
        wait_idle("f3");
        check("err_sticky", int'(zone_err), 1);

        // Frame 4: blanked
        bl_enable = 1'b0;
        lp = latch_pulses;
        for (int k = 0; k < 10; k++) wr($urandom_range(0, ZONES - 1), $urandom_range(1, 255));
        start_frame();
        wait_idle("f4");
        check("blank_latch", latch_pulses, lp + 1);
        bl_enable = 1'b1;

        // Frame 5: reset mid-shift
        for (int k = 0; k < 10; k++) wr($urandom_range(0, ZONES - 1), $urandom_range(0, 255));
        start_frame();
        repeat (150) @(posedge i_pix_clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_cs_n", int'(spi_cs_n), 1);
        check("mid_rst_sclk", int'(spi_sclk), 0);
        check("mid_rst_latch", int'(spi_latch), 0);
        check("mid_rst_busy", int'(tx_busy), 0);
        exp_q.delete();
        m_wr = 0;
        lp = latch_pulses;
        repeat (3) @(negedge i_pix_clk);
        @(posedge i_pix_clk); #1 rst = 1'b0;
        repeat (300) @(negedge i_pix_clk);
        check("no_latch_after_rst", latch_pulses, lp);
        check("cs_idle_after_rst", int'(spi_cs_n), 1);
        check("err_cleared_by_rst", int'(zone_err), 0);

        // Frame 6: normal operation after reset
        for (int k = 0; k < 15; k++) wr($urandom_range(0, ZONES - 1), $urandom_range(0, 255));
        start_frame();
        wait_idle("f6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
